// File: rtl/regfile_dump.sv
// regfile_dump: walks the register file read port x0..x(NUM_REGS-1) and streams {index, value} beats.
// Optional feature macro DUMP_CHECKSUM_EN adds a running sum of accepted beats on dump_sum.
module regfile_dump #(
  parameter int NUM_REGS = 32,
  parameter int ADDR_W   = 5,
  parameter int DATA_W   = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              abort,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] rf_raddr,
  input  logic [DATA_W-1:0] rf_rdata,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ADDR_W-1:0] out_addr,
  output logic [DATA_W-1:0] out_data
`ifdef DUMP_CHECKSUM_EN
  ,
  output logic [DATA_W-1:0] dump_sum
`endif
);

  typedef enum logic [1:0] {IDLE, READ, SEND, DONE} dumpState_t;

  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NUM_REGS - 1);

  dumpState_t        stateReg;
  logic [ADDR_W-1:0] idxReg;
  logic              handshake;
  logic              startAccept;

  assign handshake   = out_valid & out_ready;
  assign startAccept = (stateReg == IDLE) && start && !abort;
  // The register file address comes straight from the walk index, so it only moves on clock edges.
  assign rf_raddr    = idxReg;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stateReg  <= IDLE;
      idxReg    <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      out_valid <= 1'b0;
      out_addr  <= '0;
      out_data  <= '0;
    end else begin
      done <= 1'b0;
      if (abort && stateReg != IDLE) begin
        // Abort wins over a coinciding handshake; the walk is simply dropped.
        stateReg  <= IDLE;
        idxReg    <= '0;
        busy      <= 1'b0;
        out_valid <= 1'b0;
      end else begin
        case (stateReg)
          IDLE: begin
            if (startAccept) begin
              idxReg   <= '0;
              busy     <= 1'b1;
              stateReg <= READ;
            end
          end
          READ: begin
            out_addr  <= idxReg;
            out_data  <= rf_rdata;
            out_valid <= 1'b1;
            stateReg  <= SEND;
          end
          SEND: begin
            if (handshake) begin
              out_valid <= 1'b0;
              if (idxReg == LAST_IDX) begin
                done     <= 1'b1;
                stateReg <= DONE;
              end else begin
                idxReg   <= idxReg + 1'b1;
                stateReg <= READ;
              end
            end
          end
          DONE: begin
            idxReg   <= '0;
            busy     <= 1'b0;
            stateReg <= IDLE;
          end
          default: begin
            stateReg <= IDLE;
          end
        endcase
      end
    end
  end

`ifdef DUMP_CHECKSUM_EN
  logic [DATA_W-1:0] sumReg;

  // A handshake that coincides with abort still consumed its beat, so it is summed.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sumReg <= '0;
    end else if (startAccept) begin
      sumReg <= '0;
    end else if (stateReg == SEND && handshake) begin
      sumReg <= sumReg + out_data;
    end
  end

  assign dump_sum = sumReg;
`endif

endmodule

// File: tb/tb_regfile_dump.sv
// tb_regfile_dump: scoreboard bench for regfile_dump; expected beats are queued at start
// and checked as each handshake is observed. Define DUMP_CHECKSUM_EN to check dump_sum too.
module tb_regfile_dump;

  localparam int NUM_REGS = 32;
  localparam int ADDR_W   = 5;
  localparam int DATA_W   = 32;

  logic              clk;
  logic              rst_n;
  logic              start;
  logic              abort;
  logic              busy;
  logic              done;
  logic [ADDR_W-1:0] rf_raddr;
  logic [DATA_W-1:0] rf_rdata;
  logic              out_valid;
  logic              out_ready;
  logic [ADDR_W-1:0] out_addr;
  logic [DATA_W-1:0] out_data;
`ifdef DUMP_CHECKSUM_EN
  logic [DATA_W-1:0] dump_sum;
`endif

  logic [DATA_W-1:0]        rfModel [NUM_REGS];
  logic [DATA_W-1:0]        expSum;
  logic [ADDR_W+DATA_W-1:0] expQ [$];
  int                       checkCount = 0;
  int                       failCount  = 0;
  int                       doneCount  = 0;

  regfile_dump #(
    .NUM_REGS(NUM_REGS),
    .ADDR_W  (ADDR_W),
    .DATA_W  (DATA_W)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .abort    (abort),
    .busy     (busy),
    .done     (done),
    .rf_raddr (rf_raddr),
    .rf_rdata (rf_rdata),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_addr (out_addr),
    .out_data (out_data)
`ifdef DUMP_CHECKSUM_EN
    ,
    .dump_sum (dump_sum)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Combinational register file model.
  assign rf_rdata = rfModel[rf_raddr];

  task automatic checkVal(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checkCount++;
    if (got !== exp) begin
      failCount++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  // Inputs change at posedge+1, so a handshake seen at the negedge happens at the next posedge.
  always @(negedge clk) begin
    logic [ADDR_W+DATA_W-1:0] beat;
    if (done) doneCount++;
    if (rst_n && out_valid && out_ready) begin
      if (expQ.size() == 0) begin
        checkVal("unexpected beat", 64'(out_addr), 64'hFFFF);
      end else begin
        beat = expQ.pop_front();
        checkVal("beat addr", 64'(out_addr), 64'(beat[ADDR_W+DATA_W-1:DATA_W]));
        checkVal("beat data", 64'(out_data), 64'(beat[DATA_W-1:0]));
        $display("beat x%0d = %08h", out_addr, out_data);
      end
    end
  end

  task automatic runDump(input string tag, input int stallAt, input int pokeAt,
                         input int killAt, input bit useReset);
    int n;
    int stalls;
    int doneBefore;
    bit killed;
    bit poked;
    doneBefore = doneCount;
    for (int i = 0; i < NUM_REGS; i++) expQ.push_back({ADDR_W'(i), rfModel[i]});
    out_ready = 1'b1;
    start = 1'b1;
    @(posedge clk); #1;   // edge E: start sampled
    start = 1'b0;
    n = 0; stalls = 0; killed = 0; poked = 0;
    while (!done && !killed && n < 400) begin
      @(posedge clk); n++; #1;
      start = 1'b0;
      abort = 1'b0;
      if (out_valid && int'(out_addr) == stallAt && stalls < 5) begin
        checkVal({tag, " stall valid"}, 64'(out_valid), 64'd1);
        checkVal({tag, " stall addr"}, 64'(out_addr), 64'(stallAt));
        checkVal({tag, " stall data"}, 64'(out_data), 64'(rfModel[stallAt]));
        out_ready = 1'b0;
        stalls++;
      end else if (stallAt >= 0 && stalls == 5) begin
        out_ready = 1'($urandom_range(0, 1));
      end else begin
        out_ready = 1'b1;
      end
      if (!poked && out_valid && int'(out_addr) == pokeAt) begin
        start = 1'b1;
        poked = 1;
      end
      if (out_valid && int'(out_addr) == killAt) begin
        out_ready = 1'b0;
        if (useReset) rst_n = 1'b0;
        else abort = 1'b1;
        killed = 1;
      end
    end
    if (killed) begin
      @(posedge clk); #1;
      rst_n = 1'b1;
      abort = 1'b0;
      checkVal({tag, " kill valid"}, 64'(out_valid), 64'd0);
      checkVal({tag, " kill busy"}, 64'(busy), 64'd0);
      checkVal({tag, " kill done"}, 64'(done), 64'd0);
      checkVal({tag, " kill raddr"}, 64'(rf_raddr), 64'd0);
      expQ.delete();
      repeat (4) @(posedge clk);
      #1;
      checkVal({tag, " kill no done"}, 64'(doneCount - doneBefore), 64'd0);
      checkVal({tag, " kill idle"}, 64'(busy), 64'd0);
    end else begin
      checkVal({tag, " done seen"}, 64'(done), 64'd1);
      if (stallAt < 0) checkVal({tag, " done cycle"}, 64'(n), 64'(2 * NUM_REGS));
`ifdef DUMP_CHECKSUM_EN
      checkVal({tag, " dump_sum"}, 64'(dump_sum), 64'(expSum));
`endif
      @(posedge clk); #1;
      checkVal({tag, " done pulse"}, 64'(done), 64'd0);
      checkVal({tag, " busy after"}, 64'(busy), 64'd0);
      checkVal({tag, " queue empty"}, 64'(expQ.size()), 64'd0);
      checkVal({tag, " done count"}, 64'(doneCount - doneBefore), 64'd1);
`ifdef DUMP_CHECKSUM_EN
      checkVal({tag, " sum stable"}, 64'(dump_sum), 64'(expSum));
`endif
      expQ.delete();
    end
    $display("dump %s finished after %0d cycles", tag, n);
  endtask

  initial begin
    for (int i = 0; i < NUM_REGS; i++) rfModel[i] = '0;
    rfModel[5]  = 32'hAAAABBBB;
    rfModel[10] = 32'h12345678;
    rfModel[20] = 32'hCAFECAFE;
    rfModel[25] = 32'hFACEFACE;
    expSum = '0;
    for (int i = 0; i < NUM_REGS; i++) expSum = expSum + rfModel[i];

    rst_n = 1'b0; start = 1'b1; abort = 1'b0; out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checkVal("reset busy", 64'(busy), 64'd0);
    checkVal("reset valid", 64'(out_valid), 64'd0);
    checkVal("reset done", 64'(done), 64'd0);
    checkVal("reset raddr", 64'(rf_raddr), 64'd0);
    checkVal("reset addr", 64'(out_addr), 64'd0);
    checkVal("reset data", 64'(out_data), 64'd0);
    rst_n = 1'b1; start = 1'b0;
    @(posedge clk); #1;
    checkVal("post reset busy", 64'(busy), 64'd0);

    // abort and start together in IDLE: abort wins
    start = 1'b1; abort = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; abort = 1'b0;
    checkVal("abort+start idle", 64'(busy), 64'd0);

    runDump("full", -1, -1, -1, 1'b0);
    runDump("backpressure", 5, -1, -1, 1'b0);
    runDump("start busy", -1, 10, -1, 1'b0);
    runDump("abort x20", -1, -1, 20, 1'b0);
    runDump("after abort", -1, -1, -1, 1'b0);
    runDump("reset x20", -1, -1, 20, 1'b1);
    runDump("after reset", -1, -1, -1, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", checkCount, failCount);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, %0d failures so far", failCount);
    $fatal(1, "watchdog expired");
  end

endmodule
